// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer and the decoder's dispatch side:
// default geometry and the two-bit entry type encoding {control, writes_reg}.
package reorder_buffer_pkg;

    localparam int DEF_ROB_WIDTH      = 3;
    localparam int DEF_REG_WIDTH      = 5;
    localparam int DEF_ROB_TYPE_WIDTH = 2;

    typedef enum logic [1:0] {
        ROB_TYPE_STORE  = 2'b00,
        ROB_TYPE_REG    = 2'b01,
        ROB_TYPE_BRANCH = 2'b10,
        ROB_TYPE_JALR   = 2'b11
    } rob_type_e;

    // Low bit of the type code marks entries that retire into the register file.
    function automatic logic writes_reg(input logic [1:0] ty);
        return ty[0];
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail on dispatch, collects ALU/LSB
// write-backs, retires in order from head and resolves branch/JALR at retirement.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH      = DEF_ROB_WIDTH,
    parameter int REG_WIDTH      = DEF_REG_WIDTH,
    parameter int ROB_TYPE_WIDTH = DEF_ROB_TYPE_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    output logic                      flush,
    output logic [31:0]               predict_correct_pc,
    output logic                      rob_full,
    output logic [ROB_WIDTH-1:0]      rob_empty_id,
    input  logic                      rob_rdy,
    input  logic                      rob_committable,
    input  logic [31:0]               rob_res,
    input  logic [ROB_TYPE_WIDTH-1:0] rob_type,
    input  logic [REG_WIDTH-1:0]      rob_dest,
    input  logic [31:0]               rob_next_addr,
    input  logic [31:0]               rob_jump_addr,
    input  logic                      rob_predict,
    input  logic                      alu_rdy,
    input  logic [ROB_WIDTH-1:0]      alu_rob_id,
    input  logic [31:0]               alu_res,
    input  logic                      lsb_rdy,
    input  logic [ROB_WIDTH-1:0]      lsb_rob_id,
    input  logic [31:0]               lsb_res,
    output logic                      reg_commit_en,
    output logic [REG_WIDTH-1:0]      reg_commit_reg_id,
    output logic [ROB_WIDTH-1:0]      reg_commit_rob_id,
    output logic [31:0]               reg_commit_data,
    output logic                      store_commit_en,
    output logic [ROB_WIDTH-1:0]      store_commit_rob_id
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    logic [DEPTH-1:0]          busy_q, busy_d;
    logic [DEPTH-1:0]          cmt_q, cmt_d;
    logic [DEPTH-1:0]          pred_q;
    logic [ROB_TYPE_WIDTH-1:0] type_q [DEPTH];
    logic [REG_WIDTH-1:0]      dest_q [DEPTH];
    logic [31:0]               res_q  [DEPTH];
    logic [31:0]               next_q [DEPTH];
    logic [31:0]               jump_q [DEPTH];

    logic [ROB_WIDTH-1:0]      head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]        count_q, count_d;

    logic                      flush_q;
    logic [31:0]               pc_q;
    logic                      reg_en_q;
    logic [REG_WIDTH-1:0]      reg_id_q;
    logic [ROB_WIDTH-1:0]      reg_rob_q;
    logic [31:0]               reg_data_q;
    logic                      st_en_q;
    logic [ROB_WIDTH-1:0]      st_rob_q;

    logic                      accept;
    logic                      do_commit;
    logic                      do_disp;
    logic                      mispredict;
    logic [31:0]               redirect_pc;
    logic [ROB_TYPE_WIDTH-1:0] head_type;
    logic [DEPTH-1:0]          alu_sel, lsb_sel;

    // The flush cycle itself is dead: nothing is accepted while flush is high.
    assign accept    = rdy_in && !flush_q;
    assign head_type = type_q[head_q];
    assign do_commit = accept && busy_q[head_q] && cmt_q[head_q];
    assign do_disp   = accept && rob_rdy && !mispredict;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alu_sel[gi] = accept && alu_rdy && busy_q[gi] && (alu_rob_id == ROB_WIDTH'(gi));
            assign lsb_sel[gi] = accept && lsb_rdy && busy_q[gi] && (lsb_rob_id == ROB_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (do_commit) begin
            if (head_type == ROB_TYPE_JALR) begin
                mispredict  = 1'b1;
                redirect_pc = jump_q[head_q];
            end else if (head_type == ROB_TYPE_BRANCH && res_q[head_q][0] != pred_q[head_q]) begin
                mispredict  = 1'b1;
                redirect_pc = res_q[head_q][0] ? jump_q[head_q] : next_q[head_q];
            end
        end
    end

    always_comb begin
        busy_d  = busy_q;
        cmt_d   = cmt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (accept) begin
            cmt_d = cmt_q | alu_sel | lsb_sel;
            if (do_commit) begin
                busy_d[head_q] = 1'b0;
                cmt_d[head_q]  = 1'b0;
                head_d         = head_q + 1'b1;
            end
            if (do_disp) begin
                busy_d[tail_q] = 1'b1;
                cmt_d[tail_q]  = rob_committable;
                tail_d         = tail_q + 1'b1;
            end
            count_d = count_q + (ROB_WIDTH+1)'(do_disp) - (ROB_WIDTH+1)'(do_commit);
            if (mispredict) begin
                busy_d  = '0;
                cmt_d   = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            cmt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            cmt_q   <= cmt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload fields need no reset: they are only read behind busy.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && tail_q == ROB_WIDTH'(i)) begin
                type_q[i] <= rob_type;
                dest_q[i] <= rob_dest;
                res_q[i]  <= rob_res;
                next_q[i] <= rob_next_addr;
                jump_q[i] <= rob_jump_addr;
                pred_q[i] <= rob_predict;
            end else if (alu_sel[i]) begin
                case (type_q[i])
                    ROB_TYPE_REG:    res_q[i]    <= alu_res;
                    ROB_TYPE_BRANCH: res_q[i][0] <= alu_res[0];
                    ROB_TYPE_JALR:   jump_q[i]   <= alu_res;
                    default: ;
                endcase
            end else if (lsb_sel[i] && type_q[i] == ROB_TYPE_REG) begin
                res_q[i] <= lsb_res;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            flush_q    <= 1'b0;
            pc_q       <= '0;
            reg_en_q   <= 1'b0;
            reg_id_q   <= '0;
            reg_rob_q  <= '0;
            reg_data_q <= '0;
            st_en_q    <= 1'b0;
            st_rob_q   <= '0;
        end else if (rdy_in) begin
            flush_q  <= mispredict;
            pc_q     <= redirect_pc;
            reg_en_q <= do_commit && writes_reg(head_type);
            st_en_q  <= do_commit && (head_type == ROB_TYPE_STORE);
            if (do_commit) begin
                reg_id_q   <= dest_q[head_q];
                reg_rob_q  <= head_q;
                reg_data_q <= res_q[head_q];
                st_rob_q   <= head_q;
            end
        end
    end

    assign flush               = flush_q;
    assign predict_correct_pc  = pc_q;
    assign rob_full            = (count_q == (ROB_WIDTH+1)'(DEPTH));
    assign rob_empty_id        = tail_q;
    assign reg_commit_en       = reg_en_q;
    assign reg_commit_reg_id   = reg_id_q;
    assign reg_commit_rob_id   = reg_rob_q;
    assign reg_commit_data     = reg_data_q;
    assign store_commit_en     = st_en_q;
    assign store_commit_rob_id = st_rob_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against a queue-based
// model of program-order retirement.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        flush;
    logic [31:0] predict_correct_pc;
    logic        rob_full;
    logic [2:0]  rob_empty_id;
    logic        rob_rdy, rob_committable;
    logic [31:0] rob_res;
    logic [1:0]  rob_type;
    logic [4:0]  rob_dest;
    logic [31:0] rob_next_addr, rob_jump_addr;
    logic        rob_predict;
    logic        alu_rdy;
    logic [2:0]  alu_rob_id;
    logic [31:0] alu_res;
    logic        lsb_rdy;
    logic [2:0]  lsb_rob_id;
    logic [31:0] lsb_res;
    logic        reg_commit_en;
    logic [4:0]  reg_commit_reg_id;
    logic [2:0]  reg_commit_rob_id;
    logic [31:0] reg_commit_data;
    logic        store_commit_en;
    logic [2:0]  store_commit_rob_id;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush(flush), .predict_correct_pc(predict_correct_pc),
        .rob_full(rob_full), .rob_empty_id(rob_empty_id),
        .rob_rdy(rob_rdy), .rob_committable(rob_committable), .rob_res(rob_res),
        .rob_type(rob_type), .rob_dest(rob_dest), .rob_next_addr(rob_next_addr),
        .rob_jump_addr(rob_jump_addr), .rob_predict(rob_predict),
        .alu_rdy(alu_rdy), .alu_rob_id(alu_rob_id), .alu_res(alu_res),
        .lsb_rdy(lsb_rdy), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
        .reg_commit_en(reg_commit_en), .reg_commit_reg_id(reg_commit_reg_id),
        .reg_commit_rob_id(reg_commit_rob_id), .reg_commit_data(reg_commit_data),
        .store_commit_en(store_commit_en), .store_commit_rob_id(store_commit_rob_id)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         id;
        bit         cm;
        bit [1:0]   ty;
        bit [4:0]   dest;
        bit [31:0]  res;
        bit [31:0]  nxt;
        bit [31:0]  jmp;
        bit         pred;
    } ent_t;

    ent_t      rob_m[$];
    int        m_tail;
    bit        m_flush;
    bit [31:0] m_pc;
    bit        m_reg_en;
    bit [4:0]  m_reg_id;
    bit [2:0]  m_reg_rob;
    bit [31:0] m_reg_data;
    bit        m_st_en;
    bit [2:0]  m_st_rob;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the reference: retire oldest if ready, resolve, then write-backs and dispatch.
    task automatic model_cycle();
        ent_t      h;
        bit        commit;
        bit        mis;
        bit [31:0] tgt;
        if (rst_in) begin
            rob_m.delete();
            m_tail = 0; m_flush = 0; m_pc = 0;
            m_reg_en = 0; m_reg_id = 0; m_reg_rob = 0; m_reg_data = 0;
            m_st_en = 0; m_st_rob = 0;
            return;
        end
        if (!rdy_in) return;
        if (m_flush) begin
            m_flush = 0; m_pc = 0; m_reg_en = 0; m_st_en = 0;
            return;
        end
        commit = (rob_m.size() > 0) && rob_m[0].cm;
        mis = 0; tgt = 0;
        m_reg_en = 0; m_st_en = 0;
        if (commit) begin
            h = rob_m[0];
            if (h.ty == ROB_TYPE_REG || h.ty == ROB_TYPE_JALR) begin
                m_reg_en = 1; m_reg_id = h.dest; m_reg_rob = 3'(h.id); m_reg_data = h.res;
            end
            if (h.ty == ROB_TYPE_STORE) begin
                m_st_en = 1; m_st_rob = 3'(h.id);
            end
            if (h.ty == ROB_TYPE_BRANCH && h.res[0] != h.pred) begin
                mis = 1; tgt = h.res[0] ? h.jmp : h.nxt;
            end
            if (h.ty == ROB_TYPE_JALR) begin
                mis = 1; tgt = h.jmp;
            end
        end
        m_flush = mis;
        m_pc    = tgt;
        if (mis) begin
            rob_m.delete();
            m_tail = 0;
            return;
        end
        foreach (rob_m[k]) begin
            if (lsb_rdy && rob_m[k].id == int'(lsb_rob_id)) begin
                if (rob_m[k].ty == ROB_TYPE_REG) rob_m[k].res = lsb_res;
                rob_m[k].cm = 1;
            end
            if (alu_rdy && rob_m[k].id == int'(alu_rob_id)) begin
                case (rob_m[k].ty)
                    ROB_TYPE_REG:    rob_m[k].res = alu_res;
                    ROB_TYPE_BRANCH: rob_m[k].res[0] = alu_res[0];
                    ROB_TYPE_JALR:   rob_m[k].jmp = alu_res;
                    default: ;
                endcase
                rob_m[k].cm = 1;
            end
        end
        if (commit) void'(rob_m.pop_front());
        if (rob_rdy) begin
            h.id = m_tail; h.cm = rob_committable; h.ty = rob_type; h.dest = rob_dest;
            h.res = rob_res; h.nxt = rob_next_addr; h.jmp = rob_jump_addr; h.pred = rob_predict;
            rob_m.push_back(h);
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    task automatic check_all();
        check("full", rob_full, rob_m.size() == 8);
        check("empty_id", rob_empty_id, m_tail);
        check("flush", flush, m_flush);
        check("reg_en", reg_commit_en, m_reg_en);
        check("st_en", store_commit_en, m_st_en);
        if (m_flush)  check("pc", predict_correct_pc, m_pc);
        if (m_reg_en) begin
            check("reg_id", reg_commit_reg_id, m_reg_id);
            check("reg_rob", reg_commit_rob_id, m_reg_rob);
            check("reg_data", reg_commit_data, m_reg_data);
        end
        if (m_st_en)  check("st_rob", store_commit_rob_id, m_st_rob);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk_in);
        #1;
        rob_rdy = 0; alu_rdy = 0; lsb_rdy = 0;
        check_all();
    endtask

    task automatic disp(input bit [1:0] ty, input bit cm, input bit [4:0] d, input bit [31:0] r,
                        input bit [31:0] n, input bit [31:0] j, input bit p);
        rob_rdy = 1; rob_type = ty; rob_committable = cm; rob_dest = d;
        rob_res = r; rob_next_addr = n; rob_jump_addr = j; rob_predict = p;
    endtask

    task automatic alu_wb(input bit [2:0] id, input bit [31:0] v);
        alu_rdy = 1; alu_rob_id = id; alu_res = v;
    endtask

    task automatic lsb_wb(input bit [2:0] id, input bit [31:0] v);
        lsb_rdy = 1; lsb_rob_id = id; lsb_res = v;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1;
        rob_rdy = 0; rob_committable = 0; rob_res = 0; rob_type = 0; rob_dest = 0;
        rob_next_addr = 0; rob_jump_addr = 0; rob_predict = 0;
        alu_rdy = 0; alu_rob_id = 0; alu_res = 0;
        lsb_rdy = 0; lsb_rob_id = 0; lsb_res = 0;

        // Reset state
        step(); step();
        rst_in = 0;
        check("rst_flush", flush, 0);
        check("rst_pc", predict_correct_pc, 0);
        check("rst_full", rob_full, 0);
        check("rst_empty_id", rob_empty_id, 0);
        check("rst_reg_en", reg_commit_en, 0);
        check("rst_reg_data", reg_commit_data, 0);
        check("rst_st_en", store_commit_en, 0);

        // LUI: already committable, retires the next cycle
        disp(ROB_TYPE_REG, 1, 5, 32'h12345000, 0, 0, 0); step();
        check("lui_tail", rob_empty_id, 1);
        step();
        check("lui_en", reg_commit_en, 1);
        check("lui_reg", reg_commit_reg_id, 5);
        check("lui_rob", reg_commit_rob_id, 0);
        check("lui_data", reg_commit_data, 32'h12345000);
        step();
        check("lui_en_off", reg_commit_en, 0);

        // Fill all 8 entries
        rst_in = 1; step(); rst_in = 0;
        for (int i = 0; i < 8; i++) begin
            disp(ROB_TYPE_REG, 0, 5'(i + 1), 0, 0, 0, 0); step();
        end
        check("fill_full", rob_full, 1);
        check("fill_wrap", rob_empty_id, 0);
        alu_wb(0, 7); step(); step();
        check("fill_data", reg_commit_data, 7);
        check("fill_rob", reg_commit_rob_id, 0);
        check("fill_unfull", rob_full, 0);

        // Reset mid-operation while a commit pulse is up
        rst_in = 1; step(); rst_in = 0;
        check("mid_rst_reg_en", reg_commit_en, 0);
        check("mid_rst_empty", rob_empty_id, 0);
        check("mid_rst_full", rob_full, 0);

        // Out-of-order write-back, in-order retirement
        disp(ROB_TYPE_REG, 0, 1, 0, 0, 0, 0); step();
        disp(ROB_TYPE_REG, 0, 2, 0, 0, 0, 0); step();
        alu_wb(1, 32'h11); step(); step();
        check("ooo_hold", reg_commit_en, 0);
        alu_wb(0, 32'h10); step(); step();
        check("ooo_c0_rob", reg_commit_rob_id, 0);
        check("ooo_c0_data", reg_commit_data, 32'h10);
        step();
        check("ooo_c1_rob", reg_commit_rob_id, 1);
        check("ooo_c1_data", reg_commit_data, 32'h11);
        step();
        alu_wb(2, 32'h99); step();
        disp(ROB_TYPE_REG, 0, 3, 0, 0, 0, 0); step(); step(); step();
        check("stale_wb", reg_commit_en, 0);
        alu_wb(2, 32'h22); step(); step();
        check("late_data", reg_commit_data, 32'h22);
        step();

        // Branch mispredict (predicted taken, resolved not taken)
        rst_in = 1; step(); rst_in = 0;
        disp(ROB_TYPE_BRANCH, 0, 0, 0, 32'h104, 32'h200, 1); step();
        disp(ROB_TYPE_REG, 1, 4, 32'hAA, 0, 0, 0); step();
        alu_wb(0, 0); step(); step();
        check("br_flush", flush, 1);
        check("br_pc", predict_correct_pc, 32'h104);
        check("br_empty", rob_empty_id, 0);
        step();
        check("br_young", reg_commit_en, 0);
        step();
        disp(ROB_TYPE_BRANCH, 0, 0, 0, 32'h104, 32'h200, 1); step();
        alu_wb(0, 1); step(); step();
        check("br_ok_flush", flush, 0);

        // JALR always redirects and writes its link value
        disp(ROB_TYPE_JALR, 0, 1, 32'h108, 32'h108, 0, 0); step();
        alu_wb(1, 32'h300); step(); step();
        check("jalr_data", reg_commit_data, 32'h108);
        check("jalr_flush", flush, 1);
        check("jalr_pc", predict_correct_pc, 32'h300);
        step();

        // Store released after LSB resolution
        disp(ROB_TYPE_STORE, 0, 0, 0, 0, 0, 0); step();
        lsb_wb(0, 32'hDEAD); step(); step();
        check("st_en", store_commit_en, 1);
        check("st_rob", store_commit_rob_id, 0);
        step();

        // rdy_in low freezes everything
        disp(ROB_TYPE_REG, 1, 7, 32'h77, 0, 0, 0);
        rdy_in = 0; step(); step(); step();
        check("frz_empty", rob_empty_id, 1);
        check("frz_en", reg_commit_en, 0);
        rdy_in = 1;
        disp(ROB_TYPE_REG, 1, 7, 32'h77, 0, 0, 0); step();
        step();
        check("frz_commit", reg_commit_data, 32'h77);
        rdy_in = 0; step();
        check("frz_hold", reg_commit_en, 1);
        rdy_in = 1; step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_in = ($urandom_range(0, 299) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if (rob_m.size() < 8 && $urandom_range(0, 1) == 1) begin
                bit [1:0] ty;
                ty = 2'($urandom_range(0, 3));
                disp(ty, (ty == ROB_TYPE_REG) && ($urandom_range(0, 2) == 0),
                     5'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            end
            if ($urandom_range(0, 2) == 0) alu_wb(3'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) lsb_wb(3'($urandom), $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
